steer_en: RTL

//  Rider-presence and steering-enable controller. Captures left/right platform load-cell

---
 rtl/steer_en.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller: captures platform load cells and
// decides whether a rider is aboard (rider_off) and settled/balanced enough to steer (en_steer).
module steer_en #(
    parameter bit          FAST_SIM      = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [7:0]  WT_HYSTERESIS = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {5'd0, WT_HYSTERESIS};
    localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {5'd0, WT_HYSTERESIS};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t      state_r;
    state_t      nxt_state_s;
    logic [11:0] lft_hold_r;
    logic [11:0] rght_hold_r;
    logic [25:0] tmr_r;
    logic        clr_tmr_s;
    logic        tmr_full_s;

    logic [12:0] sum_s;
    logic [12:0] diff_s;
    logic [12:0] neg_diff_s;
    logic [11:0] adiff_s;
    logic        sum_gt_min_s;
    logic        sum_lt_min_s;
    logic        diff_gt_1_4_s;
    logic        diff_gt_15_16_s;

    // Capture load-cell readings on the valid strobe; all decisions use these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_hold_r  <= 12'd0;
            rght_hold_r <= 12'd0;
        end else if (ld_vld) begin
            lft_hold_r  <= lft_ld;
            rght_hold_r <= rght_ld;
        end else begin
            lft_hold_r  <= lft_hold_r;
            rght_hold_r <= rght_hold_r;
        end
    end

    // Weight sum, side-to-side imbalance and the threshold comparisons derived from them.
    always_comb begin
        sum_s           = {1'b0, lft_hold_r} + {1'b0, rght_hold_r};
        diff_s          = {1'b0, lft_hold_r} - {1'b0, rght_hold_r};
        neg_diff_s      = 13'd0 - diff_s;
        adiff_s         = diff_s[12] ? neg_diff_s[11:0] : diff_s[11:0];
        sum_gt_min_s    = (sum_s > THR_HI);
        sum_lt_min_s    = (sum_s < THR_LO);
        diff_gt_1_4_s   = ({1'b0, adiff_s} > {2'b00, sum_s[12:2]});
        diff_gt_15_16_s = ({1'b0, adiff_s} > (sum_s - {4'd0, sum_s[12:4]}));
    end

    // Settle-timer terminal count; FAST_SIM shortens it for simulation.
    always_comb begin
        tmr_full_s = 1'b0;
        if (FAST_SIM) begin
            tmr_full_s = &tmr_r[14:0];
        end else begin
            tmr_full_s = &tmr_r[25:0];
        end
    end

    // Saturating settle timer, restarted whenever the FSM asks for a fresh settle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_r <= 26'd0;
        end else if (clr_tmr_s) begin
            tmr_r <= 26'd0;
        end else if (!tmr_full_s) begin
            tmr_r <= tmr_r + 26'd1;
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Next-state logic; losing the rider outranks every balance or timer condition.
    always_comb begin
        nxt_state_s = state_r;
        clr_tmr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (sum_gt_min_s) begin
                    nxt_state_s = WAIT;
                    clr_tmr_s   = 1'b1;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            WAIT: begin
                if (sum_lt_min_s) begin
                    nxt_state_s = IDLE;
                end else if (diff_gt_1_4_s) begin
                    nxt_state_s = WAIT;
                    clr_tmr_s   = 1'b1;
                end else if (tmr_full_s) begin
                    nxt_state_s = STEER;
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            STEER: begin
                if (sum_lt_min_s) begin
                    nxt_state_s = IDLE;
                end else if (diff_gt_15_16_s) begin
                    nxt_state_s = WAIT;
                    clr_tmr_s   = 1'b1;
                end else begin
                    nxt_state_s = STEER;
                end
            end
            default: begin
                nxt_state_s = IDLE;
                clr_tmr_s   = 1'b0;
            end
        endcase
    end

    // State register and registered outputs; en_steer tracks entry/exit of STEER on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state_r   <= nxt_state_s;
            en_steer  <= (nxt_state_s == STEER);
            rider_off <= sum_lt_min_s;
        end
    end

endmodule
